// File: rtl/pure_literal_emitter.sv
// Emits one signed literal (+v / -v) per set bit of a captured pure-variable bitmap, lowest index first.
// Latency: first literal the cycle after load; done pulses the cycle after the last transfer.
// Backpressure: valid/ready; lit_out holds while lit_ready is low, and nothing depends combinationally on lit_ready.
module pure_literal_emitter #(
    parameter int WIDTH    = 9,
    parameter int OUT_SIZE = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [OUT_SIZE-1:0] pure_in,
    input  logic [OUT_SIZE-1:0] polarity_in,
    output logic                lit_valid,
    input  logic                lit_ready,
    output logic [WIDTH-1:0]    lit_out,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    count
);

    // Largest representable magnitude bounds which variable indices can ever be emitted.
    localparam int MAG_LIM  = (WIDTH > 31) ? OUT_SIZE : (1 << (WIDTH - 1));
    localparam int EMIT_LIM = (MAG_LIM < OUT_SIZE) ? MAG_LIM : OUT_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [OUT_SIZE-1:0] pending;
    logic [OUT_SIZE-1:0] polarity;
    logic [OUT_SIZE-1:0] cap_mask;
    logic [OUT_SIZE-1:0] sel_onehot;
    logic [OUT_SIZE-1:0] rest_mask;
    logic [WIDTH-1:0]    sel_idx;
    logic                sel_pos;
    logic [WIDTH-1:0]    cnt;
    logic                xfer;

    // Variable 0 is reserved and unrepresentable indices are dropped at capture.
    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            cap_mask[i] = (i != 0) && (i < EMIT_LIM) && pure_in[i];
        end
    end

    always_comb begin
        sel_idx = '0;
        sel_pos = 1'b0;
        for (int i = EMIT_LIM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = WIDTH'(i);
                sel_pos = polarity[i];
            end
        end
    end

    assign sel_onehot = pending & (-pending);
    assign rest_mask  = pending & ~sel_onehot;

    assign lit_valid = (state == SCAN) && (pending != '0);
    assign lit_out   = sel_pos ? sel_idx : (WIDTH'(0) - sel_idx);
    assign xfer      = lit_valid && lit_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            polarity <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        pending  <= cap_mask;
                        polarity <= polarity_in;
                        cnt      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (pending == '0) begin
                        state <= DONE;
                    end else if (xfer) begin
                        pending <= rest_mask;
                        cnt     <= cnt + WIDTH'(1);
                        // Finishing on the last transfer keeps done one cycle behind it.
                        if (rest_mask == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pure_literal_emitter.md
PURE_LITERAL_EMITTER -- requirements
Module: pure_literal_emitter

Interface
REQ-001 SHALL have parameter WIDTH, default 9: signed literal width (two's complement; MSB = sign).
REQ-002 SHALL have parameter OUT_SIZE, default 256: number of variable slots in the bitmaps.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: single-cycle request to capture a new bitmap pair.
REQ-006 SHALL have port pure_in, input, OUT_SIZE bits: bit v = 1 means variable v is pure.
REQ-007 SHALL have port polarity_in, input, OUT_SIZE bits: bit v = 1 means positive occurrence, 0 means negative occurrence.
REQ-008 SHALL have port lit_valid, output, 1 bit: lit_out holds a literal to be transferred.
REQ-009 SHALL have port lit_ready, input, 1 bit: consumer accepts lit_out this cycle.
REQ-010 SHALL have port lit_out, output, WIDTH bits: signed literal, +v or -v.
REQ-011 SHALL have port busy, output, 1 bit: high while the block is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-013 SHALL have port count, output, WIDTH bits: number of literals transferred in the current or most recent scan.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 In IDLE with load=1, SHALL capture pure_in into pending mask with bit 0 forced to 0 (variable 0 reserved), capture polarity_in, clear count, and enter SCAN next cycle.
REQ-016 SHALL ignore load while in SCAN or DONE; captured mask and polarity SHALL remain unchanged.
REQ-017 In SCAN, lit_valid SHALL equal (pending mask != 0).
REQ-018 lit_out SHALL be the lowest set index v of the pending mask, as +v if polarity[v]=1, else two's-complement -v.
REQ-019 lit_out and lit_valid SHALL be derived only from registered state, with no combinational path from lit_ready.
REQ-020 On lit_valid & lit_ready, SHALL clear bit v of the pending mask and increment count, both effective next cycle.
REQ-021 SHALL keep lit_out stable while lit_valid=1 and lit_ready=0.
REQ-022 SHALL transfer at most one literal per cycle; back-to-back transfers SHALL be sustained when lit_ready is held high.
REQ-023 In SCAN with pending mask == 0, SHALL enter DONE next cycle.
REQ-024 In DONE, SHALL assert done=1 for exactly one cycle, then enter IDLE.
REQ-025 An empty or bit-0-only bitmap SHALL give the sequence: load at t, SCAN at t+1 (lit_valid=0), done at t+2, IDLE at t+3, count=0.
REQ-026 Latency: for a non-empty bitmap, the first lit_valid SHALL occur the cycle after load.
REQ-027 Latency: the done pulse SHALL occur 1 cycle after the last accepted transfer.
REQ-028 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-029 count SHALL hold its value in IDLE until the next accepted load.
REQ-030 When OUT_SIZE > 2^(WIDTH-1), only indices below 2^(WIDTH-1) SHALL be emitted; higher bits SHALL be dropped at capture.

Reset
REQ-031 reset=1 SHALL take priority over load and handshake in the same cycle.
REQ-032 On reset, state SHALL be IDLE; pending mask, polarity, and count SHALL be 0; lit_valid, done, and busy SHALL be 0.
REQ-033 Reset mid-SCAN SHALL abort the scan with no done pulse; lit_valid SHALL be 0 the next cycle.

Verification
REQ-034 Load pure_in={3,5,200} with polarity bit3=1, bit5=0, bit200=1, lit_ready=1 -> lit_out +3, -5, +200 on consecutive cycles; done at the cycle after the third transfer; count=3.
REQ-035 Load pure_in=0x1 (bit 0 only) -> no lit_valid; done pulse at t+2; count=0.
REQ-036 Backpressure: pure_in={7,9}, lit_ready low for 4 cycles -> lit_out=+7 held stable 4 cycles; then transfers +7, +9 in order.
REQ-037 load pulsed during SCAN with a different bitmap -> ignored; original sequence completes unchanged.
REQ-038 reset asserted after the first transfer of a 3-literal scan -> IDLE next cycle; count=0, no done pulse; a new load then works normally.
REQ-039 All 255 bits of pure_in set, all positive, lit_ready=1 -> +1..+255 emitted in ascending order with no gaps; count=255; done 1 cycle after the last transfer.
